// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive deframer.
//   - FSM state encodings (IDLE / DATA / ERR)
//   - per-packet error codes reported with rx_eop
//   - PID type field values (pid[1:0])
//   - CRC5 / CRC16 polynomials and good-packet residuals
//   - pid_ok(): PID check-nibble test
package usb_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DATA = 2'd1;
  localparam state_t ST_ERR  = 2'd2;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_PID   = 3'd2;
  localparam logic [2:0] ERR_ALIGN = 3'd3;
  localparam logic [2:0] ERR_CRC   = 3'd4;
  localparam logic [2:0] ERR_OVF   = 3'd5;

  localparam logic [1:0] PID_TYPE_TOKEN = 2'b01;
  localparam logic [1:0] PID_TYPE_DATA  = 2'b11;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  // Upper nibble of a PID is the ones-complement of the lower nibble.
  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[3:0] == ~pid[7:4];
  endfunction

endpackage

// File: rtl/usb_crc_check.sv
// Serial USB CRC checker. Bits are fed in wire order; the transmitted
// (inverted) CRC is fed through the same register, so a good packet leaves
// the fixed residual behind.
// Ports:
//   clk, rst   - clock, async active-high reset
//   init       - preset both registers to all ones (priority over en)
//   en         - shift bit_in into the CRC registers
//   bit_in     - destuffed data bit
//   crc16_sel  - 1: judge CRC16 residual, 0: judge CRC5 residual
//   ok         - selected register holds the good-packet residual
module usb_crc_check
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic en,
  input  logic bit_in,
  input  logic crc16_sel,
  output logic ok
);

  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        fb5, fb16;

  assign fb5  = bit_in ^ crc5[4];
  assign fb16 = bit_in ^ crc16[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc5  <= '1;
      crc16 <= '1;
    end else if (init) begin
      crc5  <= '1;
      crc16 <= '1;
    end else if (en) begin
      crc5  <= {crc5[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'd0);
      crc16 <= {crc16[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'd0);
    end
  end

  assign ok = crc16_sel ? (crc16 == CRC16_RESID) : (crc5 == CRC5_RESID);

endmodule

// File: rtl/usb_rx_deframe.sv
// USB receive deframer: SYNC hunt, bit unstuffing, LSB-first byte assembly,
// SOP/EOP framing and a per-packet error code. Single clock domain (clk4x).
// Optional macro USB_RX_CRC_EN builds a CRC5/CRC16 check (error code 4).
// Ports:
//   clk4x, reset          - clock, async active-high reset
//   bit_clk, bit_in, se0  - decoded bit stream from nrzi_decode
//   rx_active             - high from SYNC until EOP
//   rx_data, rx_valid     - assembled byte + one-cycle strobe
//   rx_sop                - with rx_valid on the PID byte
//   rx_eop                - one-cycle end-of-packet pulse
//   rx_err, rx_err_code   - packet status, meaningful with rx_eop
module usb_rx_deframe
  import usb_pkg::*;
#(
  parameter int MAX_BYTES      = 1027,
  parameter int MIN_SYNC_ZEROS = 5
) (
  input  logic       clk4x,
  input  logic       reset,
  input  logic       bit_clk,
  input  logic       bit_in,
  input  logic       se0,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_err,
  output logic [2:0] rx_err_code
);

  localparam int BCW = $clog2(MAX_BYTES + 1);
  localparam int ZW  = $clog2(MIN_SYNC_ZEROS + 1) + 1;

  state_t         state;
  logic           bit_clk_q, strobe;
  logic [ZW-1:0]  zero_cnt;
  logic [2:0]     ones_cnt, bit_cnt, err_code, eop_code;
  logic [BCW-1:0] byte_cnt;
  logic [7:0]     shreg, new_byte;
  logic           crc_bad;

  assign strobe   = bit_clk & ~bit_clk_q;
  assign new_byte = {bit_in, shreg[7:1]};

  // An already-recorded error outranks anything discovered at EOP.
  assign eop_code = (err_code != ERR_NONE)              ? err_code  :
                    (bit_cnt != 3'd0 || byte_cnt == '0) ? ERR_ALIGN :
                    crc_bad                             ? ERR_CRC   : ERR_NONE;

`ifdef USB_RX_CRC_EN
  logic [1:0] pid_type;
  logic       crc_ok, crc_init, crc_en;

  // Only destuffed data bits after the PID feed the CRC.
  assign crc_init = strobe && state == ST_IDLE;
  assign crc_en   = strobe && state == ST_DATA && !se0 && ones_cnt != 3'd6 &&
                    byte_cnt != '0;
  assign crc_bad  = (pid_type == PID_TYPE_TOKEN || pid_type == PID_TYPE_DATA) &&
                    !crc_ok;

  always_ff @(posedge clk4x or posedge reset) begin
    if (reset)
      pid_type <= 2'b00;
    else if (strobe && state == ST_DATA && !se0 && ones_cnt != 3'd6 &&
             bit_cnt == 3'd7 && byte_cnt == '0)
      pid_type <= new_byte[1:0];
  end

  usb_crc_check u_crc (
    .clk      (clk4x),
    .rst      (reset),
    .init     (crc_init),
    .en       (crc_en),
    .bit_in   (bit_in),
    .crc16_sel(pid_type == PID_TYPE_DATA),
    .ok       (crc_ok)
  );
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk4x or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_clk_q   <= 1'b0;
      zero_cnt    <= '0;
      ones_cnt    <= 3'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      shreg       <= 8'd0;
      err_code    <= ERR_NONE;
      rx_active   <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      rx_sop      <= 1'b0;
      rx_eop      <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= ERR_NONE;
    end else begin
      bit_clk_q   <= bit_clk;
      rx_valid    <= 1'b0;
      rx_sop      <= 1'b0;
      rx_eop      <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= ERR_NONE;
      if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (bit_in) begin
              if (zero_cnt >= ZW'(MIN_SYNC_ZEROS)) begin
                state     <= ST_DATA;
                ones_cnt  <= 3'd1;   // SYNC's closing 1 counts toward stuffing
                bit_cnt   <= 3'd0;
                byte_cnt  <= '0;
                err_code  <= ERR_NONE;
                rx_active <= 1'b1;
              end
              zero_cnt <= '0;
            end else if (zero_cnt < ZW'(MIN_SYNC_ZEROS)) begin
              zero_cnt <= zero_cnt + ZW'(1);
            end
          end
          ST_DATA: begin
            if (se0) begin
              rx_eop      <= 1'b1;
              rx_err      <= eop_code != ERR_NONE;
              rx_err_code <= eop_code;
              rx_active   <= 1'b0;
              state       <= ST_IDLE;
            end else if (ones_cnt == 3'd6) begin
              if (bit_in) begin
                if (err_code == ERR_NONE) err_code <= ERR_STUFF;
                state <= ST_ERR;
              end else begin
                ones_cnt <= 3'd0;
              end
            end else begin
              shreg    <= new_byte;
              ones_cnt <= bit_in ? ones_cnt + 3'd1 : 3'd0;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_cnt == BCW'(MAX_BYTES)) begin
                  if (err_code == ERR_NONE) err_code <= ERR_OVF;
                  state <= ST_ERR;
                end else begin
                  rx_valid <= 1'b1;
                  rx_data  <= new_byte;
                  rx_sop   <= byte_cnt == '0;
                  byte_cnt <= byte_cnt + BCW'(1);
                  if (byte_cnt == '0 && !pid_ok(new_byte) && err_code == ERR_NONE)
                    err_code <= ERR_PID;
                end
              end
            end
          end
          ST_ERR: begin
            if (se0) begin
              rx_eop      <= 1'b1;
              rx_err      <= 1'b1;
              rx_err_code <= err_code;
              rx_active   <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_deframe.sv
// Directed bench for usb_rx_deframe (MAX_BYTES = 4 so overflow is reachable).
// A monitor collects delivered bytes and EOP status; the main sequence sends
// packets and compares against hand-computed expectations.
module tb_usb_rx_deframe;

  logic       clk4x = 1'b0, reset = 1'b1;
  logic       bit_clk = 1'b0, bit_in = 1'b1, se0 = 1'b0;
  logic       rx_active, rx_valid, rx_sop, rx_eop, rx_err;
  logic [7:0] rx_data;
  logic [2:0] rx_err_code;

  int total = 0, bad = 0;
  int tb_ones = 0;

  logic [7:0] bytes[$];
  logic       sops[$];
  int         eops = 0, clash = 0;
  logic       eop_err = 1'b0;
  logic [2:0] eop_code = 3'd0;

  usb_rx_deframe #(.MAX_BYTES(4), .MIN_SYNC_ZEROS(5)) dut (
    .clk4x(clk4x), .reset(reset), .bit_clk(bit_clk), .bit_in(bit_in), .se0(se0),
    .rx_active(rx_active), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .rx_err(rx_err), .rx_err_code(rx_err_code)
  );

  always #5 clk4x = ~clk4x;

  always @(posedge clk4x) begin
    #1;
    if (rx_valid) begin
      bytes.push_back(rx_data);
      sops.push_back(rx_sop);
    end
    if (rx_eop) begin
      eops++;
      eop_err  = rx_err;
      eop_code = rx_err_code;
    end
    if (rx_valid && rx_eop) clash++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_raw(input logic b, input logic s);
    @(negedge clk4x);
    bit_in = b; se0 = s; bit_clk = 1'b1;
    repeat (2) @(negedge clk4x);
    bit_clk = 1'b0;
    @(negedge clk4x);
  endtask

  // Sends a data bit and inserts a stuff 0 after six consecutive 1s.
  task automatic send_data(input logic b);
    send_raw(b, 1'b0);
    tb_ones = b ? tb_ones + 1 : 0;
    if (tb_ones == 6) begin
      send_raw(1'b0, 1'b0);
      tb_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data(v[i]);
  endtask

  task automatic send_sync();
    bytes.delete(); sops.delete(); eops = 0;
    for (int i = 0; i < 7; i++) send_raw(1'b0, 1'b0);
    send_raw(1'b1, 1'b0);
    tb_ones = 1;
  endtask

  task automatic send_eop();
    send_raw(1'b0, 1'b1);
    send_raw(1'b1, 1'b0);
    send_raw(1'b1, 1'b0);
  endtask

  task automatic expect_pkt(input string tag, input int n, input logic [31:0] b,
                            input logic [2:0] code);
    chk({tag, "_nbytes"}, bytes.size(), n);
    for (int i = 0; i < n && i < 4 && i < bytes.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), bytes[i], b[8*i +: 8]);
      chk($sformatf("%s_sop%0d", tag, i), sops[i], i == 0);
    end
    chk({tag, "_eops"}, eops, 1);
    chk({tag, "_err"}, eop_err, code != 3'd0);
    chk({tag, "_code"}, eop_code, code);
    chk({tag, "_active"}, rx_active, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk4x);
    chk("rst_active", rx_active, 0);
    chk("rst_outs", {rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_err_code}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk4x);

    // ACK handshake
    send_sync();
    chk("ack_active", rx_active, 1);
    send_byte(8'hD2);
    send_eop();
    expect_pkt("ack", 1, 32'h0000_00D2, 3'd0);

    // DATA0 carrying 0xFF plus CRC16 (00 FF); two stuff bits inserted
    send_sync();
    send_byte(8'hC3); send_byte(8'hFF); send_byte(8'h00); send_byte(8'hFF);
    send_eop();
    expect_pkt("stuff", 4, 32'hFF00_FFC3, 3'd0);

    // stuff violation: seventh consecutive 1
    send_sync();
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) send_raw(1'b1, 1'b0);
    send_raw(1'b0, 1'b0);
    chk("stufferr_active", rx_active, 1);
    send_eop();
    expect_pkt("stufferr", 1, 32'h0000_00C3, 3'd1);

    // PID check failure
    send_sync();
    send_byte(8'h33);
    send_eop();
    expect_pkt("pidchk", 1, 32'h0000_0033, 3'd2);

    // alignment: PID + 3 bits
    send_sync();
    send_byte(8'hD2);
    for (int i = 0; i < 3; i++) send_data(1'b0);
    send_eop();
    expect_pkt("align3", 1, 32'h0000_00D2, 3'd3);

    // alignment: SE0 right after SYNC
    send_sync();
    send_eop();
    expect_pkt("align0", 0, 32'h0, 3'd3);

    // overflow: 5 bytes into MAX_BYTES = 4
    send_sync();
    send_byte(8'hC3);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    chk("ovf_active", rx_active, 1);
    send_eop();
    expect_pkt("ovf", 4, 32'h0000_00C3, 3'd5);

    // reset mid-byte
    send_sync();
    for (int i = 0; i < 4; i++) send_data(1'b1);
    @(negedge clk4x);
    reset = 1'b1;
    #1;
    chk("midrst_outs", {rx_active, rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_err_code}, 0);
    repeat (2) @(negedge clk4x);
    reset = 1'b0;
    chk("midrst_noeop", eops, 0);
    send_sync();
    send_byte(8'hD2);
    send_eop();
    expect_pkt("postrst", 1, 32'h0000_00D2, 3'd0);

`ifdef USB_RX_CRC_EN
    send_sync();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
    send_eop();
    expect_pkt("sof_ok", 3, 32'h0010_00A5, 3'd0);

    send_sync();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    send_eop();
    expect_pkt("sof_bad", 3, 32'h0010_01A5, 3'd4);
`endif

    chk("valid_eop_clash", clash, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_rx_deframe.md
# usb_rx_deframe

Receive-side deframer sitting directly downstream of `nrzi_decode`. It consumes the decoded bit stream, bit strobe and SE0 indication, and performs four functions:
- hunts for SYNC;
- removes stuffed bits;
- assembles LSB-first bytes;
- delivers them with start/end-of-packet framing and a per-packet error code.

Its output feeds the USB packet/transaction layer. Everything runs in the `clk4x` domain.

## Interface
- `MAX_BYTES`, 1027 — max bytes per packet (PID + 1024 data + CRC16); longer packets raise an overflow error.
- `MIN_SYNC_ZEROS`, 5 — minimum run of decoded 0s before the closing 1 that counts as SYNC.

Ports:
- `clk4x`  in  1  — 4× bit-rate clock; the only clock.
- `reset`  in  1  — asynchronous, active-high.
- `bit_clk`  in  1  — `clkout` from `nrzi_decode`; its rising edge marks a new bit.
- `bit_in`  in  1  — decoded bit (`bits_out`), valid at the `bit_clk` rising edge.
- `se0`  in  1  — SE0 level from `nrzi_decode`.
- `rx_active`  out  1  — high from SYNC detect until EOP.
- `rx_data`  out  8  — assembled byte.
- `rx_valid`  out  1  — one-cycle pulse; `rx_data` is valid.
- `rx_sop`  out  1  — high with `rx_valid` on the first byte (PID).
- `rx_eop`  out  1  — one-cycle end-of-packet pulse.
- `rx_err`  out  1  — valid only with `rx_eop`; packet bad.
- `rx_err_code`  out  3  — valid with `rx_eop`:
  - 0 none
  - 1 stuff
  - 2 PID check
  - 3 alignment
  - 4 CRC
  - 5 overflow

## Operation
- Bit strobe: register `bit_clk`; strobe = `bit_clk & ~bit_clk_q`. No processing occurs between strobes.
- State machine `IDLE`, `DATA`, `ERR`:
  - `IDLE`: count consecutive 0 bits (saturating). A 1 after ≥ `MIN_SYNC_ZEROS` zeros → `DATA`. The transition sets `ones_cnt` = 1, `bit_cnt` = 0, `byte_cnt` = 0 and raises `rx_active`. Any 1 with fewer zeros clears the count. `se0` is ignored.
  - `DATA`:
    - Bit-unstuffing: on each strobe with `se0` low, if `ones_cnt` == 6 the bit is a stuff bit.
      - If it is 0: discard it and clear `ones_cnt`.
      - If it is 1: record code 1 and go to `ERR`.
    - Otherwise shift `bit_in` into the byte MSB-ward (LSB first on the wire) and update `ones_cnt` (a 1 increments, a 0 clears).
    - After the 8th bit:
      - emit `rx_valid` and increment `byte_cnt`;
      - `rx_sop` is set when `byte_cnt` was 0;
      - a first byte with `rx_data[3:0]` != `~rx_data[7:4]` records code 2 but keeps receiving.
      - a byte completing with `byte_cnt` == `MAX_BYTES` is not emitted; record code 5 and go to `ERR`.
  - EOP: `se0` high on a strobe in `DATA`.
    - Pulse `rx_eop`, drop `rx_active`, return to `IDLE`.
    - `bit_cnt` != 0 or `byte_cnt` == 0 → code 3, unless an earlier code is already recorded.
    - The first recorded error wins.
  - `ERR`: discard bits and keep `rx_active` high until a strobe with `se0` high, then pulse `rx_eop` with `rx_err` and the recorded code, and go to `IDLE`.
- `se0` and a data bit on the same strobe: `se0` wins and the bit is dropped.
- Arithmetic:
  - `ones_cnt` 3 bits;
  - `bit_cnt` 3 bits, wrapping 7→0;
  - `byte_cnt` is `$clog2(MAX_BYTES+1)` bits and never wraps, because overflow is trapped.

## Timing
- All outputs are registered and reset to 0: `rx_active`, `rx_data`, `rx_valid`, `rx_sop`, `rx_eop`, `rx_err`, `rx_err_code`. State resets to `IDLE`.
- Strobe detected in cycle N (first `clk4x` cycle with `bit_clk` high) → resulting outputs are visible in cycle N+1.
- `rx_valid`, `rx_sop`, `rx_eop` are single-cycle pulses. `rx_data` holds until the next byte.
- `rx_valid` and `rx_eop` never assert in the same cycle.
- Reset mid-packet aborts immediately. No `rx_eop` is issued for the aborted packet.

## Configuration
- `USB_RX_CRC_EN` defined: serial CRC over destuffed bits after the PID.
  - Token PIDs (`pid[1:0]` = 01) use CRC5; residual must equal 5'b01100.
  - Data PIDs (`pid[1:0]` = 11) use CRC16; residual must equal 16'h800D.
  - Handshake and special PIDs are not checked.
  - A mismatch at an otherwise clean EOP → code 4.
- Undefined: no CRC logic is built and code 4 never occurs.

## Structure
- Package `usb_pkg` holds:
  - the state enum;
  - error-code constants;
  - PID type constants;
  - CRC5/CRC16 polynomials and residuals.
- Sub-module `usb_crc_check`: serial CRC5/CRC16 with init, bit-enable and a residual-OK output. It is instantiated only under `USB_RX_CRC_EN`.

## Test plan
- ACK packet:
  - stimulus: SYNC bits 0000_0001, then PID 0xD2 LSB-first, then `se0` strobe;
  - required response: one `rx_valid` with `rx_data` = 0xD2 and `rx_sop` = 1; then `rx_eop` with `rx_err` = 0.
- Stuffing:
  - stimulus: DATA0 carrying 0xFF, with a 0 inserted after six 1s;
  - required response: bytes 0xC3, 0xFF, CRC delivered intact.
  - A 1 in place of the stuff bit → `rx_eop` with code 1 at the following SE0.
- PID check: PID 0x33 → byte delivered, `rx_eop` with code 2.
- Alignment: SE0 after PID + 3 bits → code 3. SE0 directly after SYNC → code 3.
- Overflow and reset:
  - `MAX_BYTES` = 4 with 5 bytes → 4 `rx_valid` pulses, then code 5 at SE0.
  - `reset` asserted mid-byte → all outputs 0 immediately and the next SYNC is received cleanly.
- With `USB_RX_CRC_EN`:
  - stimulus: SOF token 0xA5 0x00 0x10 (correct CRC5);
  - required response: code 0. Flipping one bit gives code 4.
